// File: rtl/cpu_pkg.sv
// cpu_pkg: shared reset/NOP constants and the fetch state encoding.
package cpu_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: 1-entry skid buffer parking a fetched word while ID is stalled.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc_plus4_in,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] pc_plus4
);
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d, pc_plus4_q, pc_plus4_d;
  always_comb begin
    valid_d    = clear ? 1'b0 : load ? 1'b1 : unload ? 1'b0 : valid_q;
    inst_d     = load ? inst_in : inst_q;
    pc_plus4_d = load ? pc_plus4_in : pc_plus4_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      inst_q     <= '0;
      pc_plus4_q <= '0;
    end else begin
      valid_q    <= valid_d;
      inst_q     <= inst_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end
  assign valid    = valid_q;
  assign inst     = inst_q;
  assign pc_plus4 = pc_plus4_q;
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: IF stage owning the PC and IF/ID register, with a req/ack imem port,
// stall hold, redirect flush and NOP bubble injection.
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid
);
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, tgt_q, tgt_d;
  logic [31:0] id_inst_q, id_inst_d, id_pc_plus4_q, id_pc_plus4_d;
  logic        id_valid_q, id_valid_d;
  logic        hb_load, hb_unload, hb_clear, hb_valid;
  logic [31:0] hb_inst, hb_pc_plus4, pc_plus4, redirect_aligned;
  assign pc_plus4         = pc_q + 32'd4;
  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
  fetch_hold_buf u_hold (
    .clk         (clk),
    .rst         (rst),
    .load        (hb_load),
    .unload      (hb_unload),
    .clear       (hb_clear),
    .inst_in     (imem_rdata),
    .pc_plus4_in (pc_plus4),
    .valid       (hb_valid),
    .inst        (hb_inst),
    .pc_plus4    (hb_pc_plus4)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    tgt_d         = tgt_q;
    id_inst_d     = id_inst_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;
    hb_load       = 1'b0;
    hb_unload     = 1'b0;
    hb_clear      = 1'b0;
    if (redirect_valid) begin
      id_inst_d  = NOP_WORD;
      id_valid_d = 1'b0;
      hb_clear   = 1'b1;
      // an unanswered request must complete before the PC may move
      if (state_q != HOLD && !imem_ack) begin
        tgt_d   = redirect_aligned;
        state_d = DRAIN;
      end else begin
        pc_d    = redirect_aligned;
        state_d = FETCH;
      end
    end else if (state_q == DRAIN) begin
      if (imem_ack) begin
        pc_d    = tgt_q;
        state_d = FETCH;
      end
    end else if (state_q == HOLD) begin
      if (!stall) begin
        id_inst_d     = hb_inst;
        id_pc_plus4_d = hb_pc_plus4;
        id_valid_d    = hb_valid;
        hb_unload     = 1'b1;
        state_d       = FETCH;
      end
    end else if (imem_ack) begin
      pc_d = pc_plus4;
      if (stall) begin
        hb_load = 1'b1;
        state_d = HOLD;
      end else begin
        id_inst_d     = imem_rdata;
        id_pc_plus4_d = pc_plus4;
        id_valid_d    = 1'b1;
      end
    end else if (!stall) begin
      id_inst_d  = NOP_WORD;
      id_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      tgt_q         <= '0;
      id_inst_q     <= NOP_WORD;
      id_pc_plus4_q <= '0;
      id_valid_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      tgt_q         <= tgt_d;
      id_inst_q     <= id_inst_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
    end
  end
  // the request drops combinationally with reset so an abandoned fetch is withdrawn at once
  always_comb begin
    imem_req  = ~rst & (state_q != HOLD);
    imem_addr = pc_q;
  end
  assign id_inst     = id_inst_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_valid    = id_valid_q;
endmodule
